// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: multi-decade BCD up/down counter with load, wrap/saturate and cascade tc
module bcd_counter_multi #(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap
);
    logic [4*DIGITS-1:0] r_count, w_next, w_clamp;
    logic                r_wrap, w_max, w_min, w_step, w_bound;
    logic [3:0]          w_d, w_l;

    // w_step ripples through the decades: a digit moves only when every lower digit is at its turn-over value
    always_comb begin
        w_next  = r_count;
        w_clamp = '0;
        w_max   = 1'b1;
        w_min   = 1'b1;
        w_step  = 1'b1;
        w_d     = '0;
        w_l     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_d = r_count[4*i +: 4];
            w_l = load_val[4*i +: 4];
            w_clamp[4*i +: 4] = (w_l > 4'd9) ? 4'd9 : w_l;
            if (w_step)
                w_next[4*i +: 4] = up_dn ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1)
                                         : ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
            w_step = w_step & (up_dn ? (w_d == 4'd9) : (w_d == 4'd0));
            w_max  = w_max & (w_d == 4'd9);
            w_min  = w_min & (w_d == 4'd0);
        end
    end

    assign w_bound = up_dn ? w_max : w_min;
    assign tc      = en & w_bound;
    assign count   = r_count;
    assign wrap    = r_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= w_clamp;
            r_wrap  <= 1'b0;
        end else if (en) begin
            if (!(SATURATE && w_bound))
                r_count <= w_next;
            r_wrap <= !SATURATE && w_bound;
        end else begin
            r_wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bcd_counter_multi.sv
// tb_bcd_counter_multi: scoreboard bench for a 2-digit wrapping and a 3-digit saturating counter
module tb_bcd_counter_multi;
    logic        clk = 1'b0;
    logic        a_rst, a_en, a_up, a_load, a_tc, a_wrap;
    logic [7:0]  a_lv, a_count;
    logic        b_rst, b_en, b_up, b_load, b_tc, b_wrap;
    logic [11:0] b_lv, b_count;

    typedef struct {
        int          sel;
        logic [11:0] cnt;
        logic        wr;
    } exp_t;
    exp_t q[$];

    int  n_err = 0;
    int  n_chk = 0;
    int  m[2];
    bit  mw[2];
    bit  valid[2];
    int  mx[2] = '{99, 999};

    always #5 clk = ~clk;

    bcd_counter_multi #(.DIGITS(2), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .count(a_count), .tc(a_tc), .wrap(a_wrap));

    bcd_counter_multi #(.DIGITS(3), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .load(b_load),
        .load_val(b_lv), .count(b_count), .tc(b_tc), .wrap(b_wrap));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_lv(input logic [11:0] v);
        int r = 0;
        for (int i = 2; i >= 0; i--)
            r = r * 10 + ((v[4*i +: 4] > 4'd9) ? 9 : int'(v[4*i +: 4]));
        return r;
    endfunction

    task automatic step(input int sel, input bit r, input bit l, input bit e, input bit u,
                        input logic [11:0] lv);
        exp_t x;
        @(negedge clk);
        if (sel == 0) begin
            a_rst = r; a_load = l; a_en = e; a_up = u; a_lv = lv[7:0];
        end else begin
            b_rst = r; b_load = l; b_en = e; b_up = u; b_lv = lv;
        end
        #1;
        if (valid[sel])
            chk(sel == 0 ? "tc_a" : "tc_b", (sel == 0) ? a_tc : b_tc,
                32'(e && (u ? m[sel] == mx[sel] : m[sel] == 0)));
        if (r) begin
            m[sel] = 0; mw[sel] = 0; valid[sel] = 1;
        end else if (l) begin
            m[sel] = (sel == 0) ? from_lv({4'd0, lv[7:0]}) : from_lv(lv);
            mw[sel] = 0;
        end else if (e) begin
            mw[sel] = 0;
            if (u && m[sel] == mx[sel]) begin
                if (sel == 0) begin m[sel] = 0; mw[sel] = 1; end
            end else if (!u && m[sel] == 0) begin
                if (sel == 0) begin m[sel] = mx[sel]; mw[sel] = 1; end
            end else begin
                m[sel] = u ? m[sel] + 1 : m[sel] - 1;
            end
        end else begin
            mw[sel] = 0;
        end
        x.sel = sel; x.cnt = to_bcd(m[sel]); x.wr = mw[sel];
        q.push_back(x);
        @(posedge clk);
        #1;
        x = q.pop_front();
        if (x.sel == 0) begin
            chk("count_a", {24'd0, a_count}, {24'd0, x.cnt[7:0]});
            chk("wrap_a", a_wrap, x.wr);
        end else begin
            chk("count_b", {20'd0, b_count}, {20'd0, x.cnt});
            chk("wrap_b", b_wrap, x.wr);
        end
    endtask

    initial begin
        {a_rst, a_en, a_up, a_load, a_lv} = '0;
        {b_rst, b_en, b_up, b_load, b_lv} = '0;
        valid = '{0, 0};
        // 2-digit wrapping counter
        step(0, 1, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 1, 12'h010);
        for (int i = 0; i < 13; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1, 12'h0AF);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 12'h056);
        step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        // reset while a wrap is about to happen cancels it
        step(0, 0, 1, 0, 1, 12'h099);
        step(0, 1, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0, 12'h0F3);
        for (int i = 0; i < 60; i++)
            step(0, 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)));
        // 3-digit saturating counter
        step(1, 1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 1, 12'h998);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 12'h001);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1, 12'h099);
        step(1, 0, 0, 1, 1, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
